reg_file: RTL and testbench

- Architectural register file with rename tags. Sits directly downstream of the reorder buffer's commit port and beside the decoder.
- Holds 32 committed values. Each register also carries a busy bit and the ROB id of its youngest in-flight producer.
- The decoder reads source operands and renames the destination of each issued instruction. ROB commits write values and clear busy tags. A flush drops every pending tag.

---
 rtl/reg_file_pkg.sv | 9 +
 rtl/reg_file_read_port.sv | 38 +++
 rtl/reg_file.sv | 102 ++++++++++
 tb/tb_reg_file.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared widths for the architectural register file and its read ports.
package reg_file_pkg;

  localparam int unsigned REG_NUM_WIDTH  = 5;
  localparam int unsigned ROB_SIZE_WIDTH = 5;
  localparam int unsigned NUM_REGS       = 32'(1) << REG_NUM_WIDTH;
  localparam int unsigned DATA_W         = 32;

endpackage : reg_file_pkg

// File: rtl/reg_file_read_port.sv
// Combinational operand read: x0 forced to zero, same-cycle commit bypassed
// only when the committing ROB entry is the register's current producer.
module reg_file_read_port
  import reg_file_pkg::*;
(
  input  logic [REG_NUM_WIDTH-1:0]                    rs,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]             values,
  input  logic [NUM_REGS-1:0]                         busy,
  input  logic [NUM_REGS-1:0][ROB_SIZE_WIDTH-1:0]     deps,
  input  logic                                        commit_valid,
  input  logic [REG_NUM_WIDTH-1:0]                    commit_rd,
  input  logic [DATA_W-1:0]                           commit_value,
  input  logic [ROB_SIZE_WIDTH-1:0]                   commit_rob_id,
  output logic [DATA_W-1:0]                           value_c,
  output logic                                        busy_c,
  output logic [ROB_SIZE_WIDTH-1:0]                   dep_c
);

  logic bypass_hit;

  always_comb begin
    bypass_hit = commit_valid && (commit_rd == rs) && busy[rs] &&
                 (deps[rs] == commit_rob_id);
    value_c = values[rs];
    busy_c  = busy[rs];
    dep_c   = deps[rs];
    if (rs == '0) begin
      value_c = '0;
      busy_c  = 1'b0;
      dep_c   = '0;
    end else if (bypass_hit) begin
      value_c = commit_value;
      busy_c  = 1'b0;
      dep_c   = '0;
    end
  end

endmodule : reg_file_read_port

// File: rtl/reg_file.sv
// Architectural register file with per-register busy bit and producer ROB tag;
// committed by the ROB, renamed by the decoder, tags dropped on flush.
module reg_file
  import reg_file_pkg::*;
(
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       flush_in,
  input  logic                       commit_valid,
  input  logic [REG_NUM_WIDTH-1:0]   commit_rd,
  input  logic [DATA_W-1:0]          commit_value,
  input  logic [ROB_SIZE_WIDTH-1:0]  commit_rob_id,
  input  logic                       dec_valid,
  input  logic [REG_NUM_WIDTH-1:0]   dec_rd,
  input  logic [ROB_SIZE_WIDTH-1:0]  dec_rob_id,
  input  logic [REG_NUM_WIDTH-1:0]   dec_rs1,
  input  logic [REG_NUM_WIDTH-1:0]   dec_rs2,
  output logic [DATA_W-1:0]          rs1_value_out,
  output logic                       rs1_busy_out,
  output logic [ROB_SIZE_WIDTH-1:0]  rs1_dep_out,
  output logic [DATA_W-1:0]          rs2_value_out,
  output logic                       rs2_busy_out,
  output logic [ROB_SIZE_WIDTH-1:0]  rs2_dep_out
);

  logic [NUM_REGS-1:0][DATA_W-1:0]         value_q, value_d;
  logic [NUM_REGS-1:0]                     busy_q, busy_d;
  logic [NUM_REGS-1:0][ROB_SIZE_WIDTH-1:0] dep_q, dep_d;

  logic commit_wr;
  logic commit_clr;
  logic rename_wr;

  // Next state: commit writes value and may retire the tag, then flush drops
  // all tags, otherwise a rename claims the register (overriding the clear).
  always_comb begin
    value_d    = value_q;
    busy_d     = busy_q;
    dep_d      = dep_q;
    commit_wr  = rdy_in && commit_valid && (commit_rd != '0);
    commit_clr = commit_wr && busy_q[commit_rd] &&
                 (dep_q[commit_rd] == commit_rob_id);
    rename_wr  = rdy_in && dec_valid && (dec_rd != '0) && !flush_in;

    if (commit_wr) begin
      value_d[commit_rd] = commit_value;
    end
    if (commit_clr) begin
      busy_d[commit_rd] = 1'b0;
    end
    if (rdy_in && flush_in) begin
      busy_d = '0;
    end
    if (rename_wr) begin
      busy_d[dec_rd] = 1'b1;
      dep_d[dec_rd]  = dec_rob_id;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      value_q <= '0;
      busy_q  <= '0;
      dep_q   <= '0;
    end else begin
      value_q <= value_d;
      busy_q  <= busy_d;
      dep_q   <= dep_d;
    end
  end

  // Read ports see stored state only; a same-cycle rename is never visible.
  reg_file_read_port u_rs1 (
    .rs            (dec_rs1),
    .values        (value_q),
    .busy          (busy_q),
    .deps          (dep_q),
    .commit_valid  (commit_valid),
    .commit_rd     (commit_rd),
    .commit_value  (commit_value),
    .commit_rob_id (commit_rob_id),
    .value_c       (rs1_value_out),
    .busy_c        (rs1_busy_out),
    .dep_c         (rs1_dep_out)
  );

  reg_file_read_port u_rs2 (
    .rs            (dec_rs2),
    .values        (value_q),
    .busy          (busy_q),
    .deps          (dep_q),
    .commit_valid  (commit_valid),
    .commit_rd     (commit_rd),
    .commit_value  (commit_value),
    .commit_rob_id (commit_rob_id),
    .value_c       (rs2_value_out),
    .busy_c        (rs2_busy_out),
    .dep_c         (rs2_dep_out)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios with constant expectations
// plus a randomized run against an array-based reference model.
module tb_reg_file;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [4:0]  commit_rob_id;
  logic        dec_valid;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rob_id;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [31:0] rs1_value_out;
  logic        rs1_busy_out;
  logic [4:0]  rs1_dep_out;
  logic [31:0] rs2_value_out;
  logic        rs2_busy_out;
  logic [4:0]  rs2_dep_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mv [32];
  logic        mb [32];
  logic [4:0]  md [32];

  reg_file dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .flush_in      (flush_in),
    .commit_valid  (commit_valid),
    .commit_rd     (commit_rd),
    .commit_value  (commit_value),
    .commit_rob_id (commit_rob_id),
    .dec_valid     (dec_valid),
    .dec_rd        (dec_rd),
    .dec_rob_id    (dec_rob_id),
    .dec_rs1       (dec_rs1),
    .dec_rs2       (dec_rs2),
    .rs1_value_out (rs1_value_out),
    .rs1_busy_out  (rs1_busy_out),
    .rs1_dep_out   (rs1_dep_out),
    .rs2_value_out (rs2_value_out),
    .rs2_busy_out  (rs2_busy_out),
    .rs2_dep_out   (rs2_dep_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mv[i] = '0;
      mb[i] = 1'b0;
      md[i] = '0;
    end
  endtask

  // Architectural rules applied at a clock edge.
  task automatic model_update();
    bit clr;
    clr = 1'b0;
    if (commit_valid && commit_rd != 0) begin
      clr = mb[commit_rd] && (md[commit_rd] == commit_rob_id);
      mv[commit_rd] = commit_value;
    end
    if (clr) mb[commit_rd] = 1'b0;
    if (flush_in) begin
      for (int i = 0; i < 32; i++) mb[i] = 1'b0;
    end else if (dec_valid && dec_rd != 0) begin
      mb[dec_rd] = 1'b1;
      md[dec_rd] = dec_rob_id;
    end
  endtask

  // Expected {value, busy, dep-if-busy} for a read of rs this cycle.
  function automatic logic [37:0] exp_port(input logic [4:0] rs);
    if (rs == 0) return '0;
    if (commit_valid && commit_rd == rs && mb[rs] && md[rs] == commit_rob_id)
      return {commit_value, 1'b0, 5'd0};
    return {mv[rs], mb[rs], mb[rs] ? md[rs] : 5'd0};
  endfunction

  function automatic logic [37:0] act_port(input logic [31:0] v, input logic b,
                                           input logic [4:0] d);
    return {v, b, b ? d : 5'd0};
  endfunction

  task automatic idle();
    rdy_in = 1'b1; flush_in = 1'b0;
    commit_valid = 1'b0; commit_rd = '0; commit_value = '0; commit_rob_id = '0;
    dec_valid = 1'b0; dec_rd = '0; dec_rob_id = '0;
    dec_rs1 = '0; dec_rs2 = '0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    if (rst_in && rdy_in) model_update();
    @(negedge clk_in);
  endtask

  task automatic rename(input logic [4:0] rd, input logic [4:0] id);
    idle(); dec_valid = 1'b1; dec_rd = rd; dec_rob_id = id;
    tick();
  endtask

  task automatic set_commit(input logic [4:0] rd, input logic [4:0] id, input logic [31:0] v);
    commit_valid = 1'b1; commit_rd = rd; commit_rob_id = id; commit_value = v;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; idle(); model_reset();
    dec_rs1 = 5'd5; dec_rs2 = 5'd0;
    #1;
    n_tests++;
    if ({rs1_value_out, rs1_busy_out} !== 33'd0) begin
      n_fail++; $display("FAIL reset_rs1 got %h/%b want 0/0", rs1_value_out, rs1_busy_out);
    end
    n_tests++;
    if ({rs2_value_out, rs2_busy_out, rs2_dep_out} !== 38'd0) begin
      n_fail++; $display("FAIL reset_rs2 got %h/%b/%0d want 0/0/0", rs2_value_out, rs2_busy_out, rs2_dep_out);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    rename(5'd7, 5'd3);
    idle(); dec_rs1 = 5'd7; #1;
    n_tests++;
    if ({rs1_busy_out, rs1_dep_out} !== {1'b1, 5'd3}) begin
      n_fail++; $display("FAIL rename_x7 got %b/%0d want 1/3", rs1_busy_out, rs1_dep_out);
    end
    #2 rst_in = 1'b0;
    #1;
    n_tests++;
    if ({rs1_value_out, rs1_busy_out} !== 33'd0) begin
      n_fail++; $display("FAIL async_reset got %h/%b want 0/0", rs1_value_out, rs1_busy_out);
    end
    model_reset();
    tick();
    rst_in = 1'b1;
  endtask

  task automatic test_bypass();
    rename(5'd3, 5'd4);
    idle(); set_commit(5'd3, 5'd4, 32'h1234); dec_rs1 = 5'd3; #1;
    n_tests++;
    if ({rs1_value_out, rs1_busy_out} !== {32'h1234, 1'b0}) begin
      n_fail++; $display("FAIL bypass got %h/%b want 1234/0", rs1_value_out, rs1_busy_out);
    end
    tick();
    idle(); dec_rs1 = 5'd3; #1;
    n_tests++;
    if ({rs1_value_out, rs1_busy_out} !== {32'h1234, 1'b0}) begin
      n_fail++; $display("FAIL commit_stored got %h/%b want 1234/0", rs1_value_out, rs1_busy_out);
    end
  endtask

  task automatic test_younger_producer();
    rename(5'd3, 5'd4);
    rename(5'd3, 5'd9);
    idle(); set_commit(5'd3, 5'd4, 32'hAA); dec_rs2 = 5'd3; #1;
    n_tests++;
    if ({rs2_value_out, rs2_busy_out, rs2_dep_out} !== {32'h1234, 1'b1, 5'd9}) begin
      n_fail++; $display("FAIL stale_no_bypass got %h/%b/%0d want 1234/1/9", rs2_value_out, rs2_busy_out, rs2_dep_out);
    end
    tick();
    idle(); dec_rs2 = 5'd3; #1;
    n_tests++;
    if ({rs2_value_out, rs2_busy_out, rs2_dep_out} !== {32'hAA, 1'b1, 5'd9}) begin
      n_fail++; $display("FAIL stale_commit got %h/%b/%0d want aa/1/9", rs2_value_out, rs2_busy_out, rs2_dep_out);
    end
  endtask

  task automatic test_same_cycle();
    idle(); set_commit(5'd8, 5'd2, 32'h55);
    dec_valid = 1'b1; dec_rd = 5'd8; dec_rob_id = 5'd6;
    tick();
    idle(); dec_rs1 = 5'd8; #1;
    n_tests++;
    if ({rs1_value_out, rs1_busy_out, rs1_dep_out} !== {32'h55, 1'b1, 5'd6}) begin
      n_fail++; $display("FAIL commit_rename_same got %h/%b/%0d want 55/1/6", rs1_value_out, rs1_busy_out, rs1_dep_out);
    end
    idle(); dec_valid = 1'b1; dec_rd = 5'd1; dec_rob_id = 5'd3; dec_rs1 = 5'd1; #1;
    n_tests++;
    if ({rs1_value_out, rs1_busy_out} !== 33'd0) begin
      n_fail++; $display("FAIL read_pre_rename got %h/%b want 0/0", rs1_value_out, rs1_busy_out);
    end
    tick();
    idle(); dec_rs1 = 5'd1; #1;
    n_tests++;
    if ({rs1_busy_out, rs1_dep_out} !== {1'b1, 5'd3}) begin
      n_fail++; $display("FAIL rename_after got %b/%0d want 1/3", rs1_busy_out, rs1_dep_out);
    end
  endtask

  task automatic test_flush();
    rename(5'd10, 5'd10);
    rename(5'd11, 5'd11);
    rename(5'd12, 5'd12);
    idle(); flush_in = 1'b1; set_commit(5'd10, 5'd10, 32'h77);
    dec_valid = 1'b1; dec_rd = 5'd13; dec_rob_id = 5'd1;
    tick();
    idle(); dec_rs1 = 5'd10; dec_rs2 = 5'd11; #1;
    n_tests++;
    if ({rs1_value_out, rs1_busy_out} !== {32'h77, 1'b0}) begin
      n_fail++; $display("FAIL flush_commit got %h/%b want 77/0", rs1_value_out, rs1_busy_out);
    end
    n_tests++;
    if (rs2_busy_out !== 1'b0) begin
      n_fail++; $display("FAIL flush_x11 got busy %b want 0", rs2_busy_out);
    end
    dec_rs1 = 5'd12; dec_rs2 = 5'd13; #1;
    n_tests++;
    if ({rs1_busy_out, rs2_busy_out} !== 2'b00) begin
      n_fail++; $display("FAIL flush_x12_x13 got %b%b want 00", rs1_busy_out, rs2_busy_out);
    end
  endtask

  task automatic test_x0_and_rdy();
    idle(); set_commit(5'd0, 5'd5, 32'hFFFF_FFFF);
    dec_valid = 1'b1; dec_rd = 5'd0; dec_rob_id = 5'd5;
    tick();
    idle(); #1;
    n_tests++;
    if ({rs1_value_out, rs1_busy_out, rs2_value_out, rs2_busy_out} !== 66'd0) begin
      n_fail++; $display("FAIL x0 got %h/%b want 0/0", rs1_value_out, rs1_busy_out);
    end
    idle(); set_commit(5'd20, 5'd0, 32'h11);
    tick();
    idle(); rdy_in = 1'b0; set_commit(5'd20, 5'd0, 32'h22);
    dec_valid = 1'b1; dec_rd = 5'd21; dec_rob_id = 5'd7; dec_rs1 = 5'd20; #1;
    n_tests++;
    if ({rs1_value_out, rs1_busy_out} !== {32'h11, 1'b0}) begin
      n_fail++; $display("FAIL rdy_low_read got %h/%b want 11/0", rs1_value_out, rs1_busy_out);
    end
    tick();
    idle(); dec_rs1 = 5'd20; dec_rs2 = 5'd21; #1;
    n_tests++;
    if ({rs1_value_out, rs1_busy_out, rs2_busy_out} !== {32'h11, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL rdy_low_hold got %h/%b/%b want 11/0/0", rs1_value_out, rs1_busy_out, rs2_busy_out);
    end
  endtask

  task automatic test_idempotent();
    rename(5'd15, 5'd8);
    for (int i = 0; i < 3; i++) begin
      idle(); set_commit(5'd15, 5'd8, 32'hBEEF);
      tick();
    end
    idle(); dec_rs1 = 5'd15; #1;
    n_tests++;
    if ({rs1_value_out, rs1_busy_out} !== {32'hBEEF, 1'b0}) begin
      n_fail++; $display("FAIL commit_hold got %h/%b want beef/0", rs1_value_out, rs1_busy_out);
    end
  endtask

  task automatic test_random();
    logic [37:0] e1, e2;
    for (int c = 0; c < 500; c++) begin
      idle();
      flush_in      = ($urandom_range(0, 15) == 0);
      commit_valid  = $urandom_range(0, 1) == 1;
      commit_rd     = 5'($urandom_range(0, 7));
      commit_rob_id = 5'($urandom_range(0, 3));
      commit_value  = $urandom;
      dec_valid     = $urandom_range(0, 1) == 1;
      dec_rd        = 5'($urandom_range(0, 7));
      dec_rob_id    = 5'($urandom_range(0, 3));
      dec_rs1       = 5'($urandom_range(0, 7));
      dec_rs2       = 5'($urandom_range(0, 7));
      #1;
      e1 = exp_port(dec_rs1);
      e2 = exp_port(dec_rs2);
      n_tests++;
      if (act_port(rs1_value_out, rs1_busy_out, rs1_dep_out) !== e1) begin
        n_fail++; $display("FAIL rand_rs1 cyc %0d rs %0d got %h want %h", c, dec_rs1,
                           act_port(rs1_value_out, rs1_busy_out, rs1_dep_out), e1);
      end
      n_tests++;
      if (act_port(rs2_value_out, rs2_busy_out, rs2_dep_out) !== e2) begin
        n_fail++; $display("FAIL rand_rs2 cyc %0d rs %0d got %h want %h", c, dec_rs2,
                           act_port(rs2_value_out, rs2_busy_out, rs2_dep_out), e2);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_younger_producer();
    test_same_cycle();
    test_flush();
    test_x0_and_rdy();
    test_idempotent();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_reg_file
